// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions for the CC2420 link (used by both the master and the responder).
// Mode-0 constants, FSM encoding, byte width and the default underrun byte.
package spi_defs;
  localparam int        BYTE_W            = 8;
  localparam bit        SPI_CPOL          = 1'b0;
  localparam bit        SPI_CPHA          = 1'b0;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

  typedef logic [BYTE_W-1:0] spi_byte_t;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_t;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the byte handshake shared with the master side.
interface spi_slave_if;
  import spi_defs::*;

  logic      SClk;
  logic      CS_;
  logic      SI;
  logic      SO;
  spi_byte_t In;
  logic      InValid;
  logic      InRequest;
  spi_byte_t Out;
  logic      NewData;
  logic      Active;

  modport slave (
    input  SClk, CS_, SI, In, InValid,
    output SO, InRequest, Out, NewData, Active
  );

  modport master (
    output SClk, CS_, SI, In, InValid,
    input  SO, InRequest, Out, NewData, Active
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer with a third history flop for edge detection of an async pin.
module spi_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  // [0],[1] synchronize; [2] is the previous synchronized value
  logic [2:0] stage_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stage_reg <= 3'b000;
    end else begin
      stage_reg <= {stage_reg[1:0], din};
    end
  end

  assign sync = stage_reg[1];
  assign rise = stage_reg[1] & ~stage_reg[2];
  assign fall = ~stage_reg[1] & stage_reg[2];
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples SClk/CS_/SI, shifts bytes MSB first and exposes
// a single-entry transmit holding register and a received-byte strobe.
module spi_slave
  import spi_defs::*;
#(
  parameter spi_byte_t IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  spi_slave_if.slave bus
);
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic sel_start, sel_end, cs_level_unused;
  logic [1:0] si_sync_reg;
  logic si_sync;

  spi_sync u_sclk_sync (
    .Clock (Clock),
    .Reset (Reset),
    .din   (bus.SClk),
    .sync  (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // CS_ is active low: its falling edge starts a frame, its rising edge ends one
  spi_sync u_cs_sync (
    .Clock (Clock),
    .Reset (Reset),
    .din   (bus.CS_),
    .sync  (cs_level_unused),
    .rise  (sel_end),
    .fall  (sel_start)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      si_sync_reg <= 2'b00;
    end else begin
      si_sync_reg <= {si_sync_reg[0], bus.SI};
    end
  end
  assign si_sync = si_sync_reg[1];

  spi_state_t state_reg;
  logic [2:0] bitcnt_reg;
  spi_byte_t  rx_shift_reg, tx_shift_reg, out_reg, hold_reg;
  logic       so_reg, new_data_reg, full_reg;
  logic       load, consume;
  spi_byte_t  tx_next;

  // A byte boundary is either the start of a frame or the fall that closes a full byte
  assign consume = ((state_reg == SPI_IDLE) && sel_start) ||
                   ((state_reg == SPI_ACTIVE) && !sel_end && sclk_fall && (bitcnt_reg == 3'd0));
  assign load    = bus.InValid && !full_reg;
  assign tx_next = full_reg ? hold_reg : IDLE_BYTE;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hold_reg <= '0;
      full_reg <= 1'b0;
    end else if (load) begin
      hold_reg <= bus.In;
      full_reg <= 1'b1;
    end else if (consume) begin
      full_reg <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= SPI_IDLE;
      bitcnt_reg   <= 3'd0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      out_reg      <= '0;
      so_reg       <= 1'b0;
      new_data_reg <= 1'b0;
    end else begin
      new_data_reg <= 1'b0;
      case (state_reg)
        SPI_IDLE: begin
          if (sel_start) begin
            state_reg    <= SPI_ACTIVE;
            bitcnt_reg   <= 3'd0;
            tx_shift_reg <= tx_next;
            so_reg       <= tx_next[7];
          end
        end
        SPI_ACTIVE: begin
          // Ending mid-byte simply drops the partial byte in both directions
          if (sel_end) begin
            state_reg <= SPI_IDLE;
            so_reg    <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift_reg <= {rx_shift_reg[6:0], si_sync};
              bitcnt_reg   <= bitcnt_reg + 3'd1;
              if (bitcnt_reg == 3'd7) begin
                out_reg      <= {rx_shift_reg[6:0], si_sync};
                new_data_reg <= 1'b1;
              end
            end
            if (sclk_fall) begin
              if (bitcnt_reg == 3'd0) begin
                tx_shift_reg <= tx_next;
                so_reg       <= tx_next[7];
              end else begin
                tx_shift_reg <= tx_shift_reg << 1;
                so_reg       <= tx_shift_reg[6];
              end
            end
          end
        end
        default: state_reg <= SPI_IDLE;
      endcase
    end
  end

  assign bus.SO        = so_reg;
  assign bus.Out       = out_reg;
  assign bus.NewData   = new_data_reg;
  assign bus.InRequest = ~full_reg;
  assign bus.Active    = (state_reg == SPI_ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master driver, a byte-level model of the
// holding register and receive stream, and a per-cycle compare of Out/NewData.
module tb_spi_slave;
  import spi_defs::*;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  spi_slave_if bus ();

  spi_slave #(.IDLE_BYTE(8'h00)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  localparam logic [7:0] IDLE_B = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;
  int nd_count = 0;

  // Model: bytes the master has fully sent (awaiting NewData), last received byte,
  // and the one-entry transmit buffer as the host sees it.
  logic [7:0] exp_rx[$];
  logic [7:0] m_out  = 8'h00;
  logic       m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic       nd_prev = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %02h, required %02h", name, act, req);
  endtask

  // Per-cycle compare of the receive side against the model
  always @(negedge Clock) begin
    if (!Reset) begin
      m_out   = 8'h00;
      nd_prev = 1'b0;
    end else begin
      if (bus.NewData === 1'b1) begin
        nd_count++;
        check("newdata_width", {7'b0, nd_prev}, 8'h00);
        if (exp_rx.size() == 0) begin
          check("newdata_unexpected", 8'(exp_rx.size()), 8'd1);
        end else begin
          m_out = exp_rx.pop_front();
          check("out_on_newdata", bus.Out, m_out);
        end
      end else begin
        check("out_stable", bus.Out, m_out);
      end
      nd_prev = bus.NewData;
    end
  end

  task automatic model_take(output logic [7:0] b);
    if (m_full) begin
      b      = m_hold;
      m_full = 1'b0;
    end else begin
      b = IDLE_B;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_so"},        {7'b0, bus.SO},        8'h00);
    check({tag, "_out"},       bus.Out,               8'h00);
    check({tag, "_newdata"},   {7'b0, bus.NewData},   8'h00);
    check({tag, "_active"},    {7'b0, bus.Active},    8'h00);
    check({tag, "_inrequest"}, {7'b0, bus.InRequest}, 8'h01);
  endtask

  task automatic load_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge Clock);
    while (bus.InRequest !== 1'b1 && waited < 1000) begin
      @(negedge Clock);
      waited++;
    end
    check("load_wait_inrequest", {7'b0, bus.InRequest}, 8'h01);
    bus.In      = b;
    bus.InValid = 1'b1;
    @(negedge Clock);
    bus.InValid = 1'b0;
    m_hold = b;
    m_full = 1'b1;
    check("inrequest_after_load", {7'b0, bus.InRequest}, 8'h00);
    $display("load     In=%02h", b);
  endtask

  // CS_ falls; the first SO bit and Active must appear exactly two edges after sampling
  task automatic cs_low(output logic [7:0] exp0, output logic ir2);
    @(negedge Clock);
    bus.CS_ = 1'b0;
    model_take(exp0);
    @(negedge Clock);
    @(negedge Clock);
    ir2 = bus.InRequest;
    check("active_before_latency", {7'b0, bus.Active}, 8'h00);
    @(negedge Clock);
    check("active_at_latency",  {7'b0, bus.Active},    8'h01);
    check("so_first_bit",       {7'b0, bus.SO},        {7'b0, exp0[7]});
    check("inrequest_consumed", {7'b0, bus.InRequest}, 8'h01);
    repeat (5) @(negedge Clock);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    if (nbits == 8) exp_rx.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      bus.SI = mo[7-i];
      repeat (8) @(negedge Clock);
      bus.SClk = 1'b1;
      mi = {mi[6:0], bus.SO};
      repeat (8) @(negedge Clock);
      bus.SClk = 1'b0;
    end
  endtask

  task automatic cs_high();
    repeat (8) @(negedge Clock);
    bus.CS_ = 1'b1;
    repeat (8) @(negedge Clock);
    check("active_after_frame", {7'b0, bus.Active}, 8'h00);
    check("so_idle",            {7'b0, bus.SO},     8'h00);
    repeat (8) @(negedge Clock);
  endtask

  task automatic frame(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                       output logic [7:0] so0, output logic [7:0] so1, output logic ir2);
    logic [7:0] e0, e1, dummy;
    cs_low(e0, ir2);
    xfer(b0, 8, so0);
    model_take(e1);
    check("so_byte0_model", so0, e0);
    $display("frame    SI=%02h SO=%02h", b0, so0);
    so1 = 8'h00;
    if (nbytes > 1) begin
      xfer(b1, 8, so1);
      model_take(dummy);
      check("so_byte1_model", so1, e1);
      $display("frame    SI=%02h SO=%02h", b1, so1);
    end
    cs_high();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] so0, so1, e0, mi;
    logic       ir2;

    bus.SClk    = 1'b0;
    bus.CS_     = 1'b1;
    bus.SI      = 1'b0;
    bus.In      = 8'h00;
    bus.InValid = 1'b0;

    repeat (4) @(negedge Clock);
    check_reset("reset_init");
    Reset = 1'b1;
    repeat (4) @(negedge Clock);

    // Single byte
    load_byte(8'hA5);
    frame(1, 8'h3C, 8'h00, so0, so1, ir2);
    check("single_so",          so0,              8'hA5);
    check("single_ir_pre",      {7'b0, ir2},      8'h00);
    check("single_out",         bus.Out,          8'h3C);
    check("single_nd_count",    8'(nd_count),     8'd1);

    // Burst: second byte loaded once the first is consumed
    load_byte(8'h81);
    fork
      frame(2, 8'h12, 8'h34, so0, so1, ir2);
      load_byte(8'h7E);
    join
    check("burst_so0",          so0,              8'h81);
    check("burst_so1",          so1,              8'h7E);
    check("burst_out",          bus.Out,          8'h34);
    check("burst_nd_count",     8'(nd_count),     8'd3);

    // Underrun
    frame(1, 8'hFF, 8'h00, so0, so1, ir2);
    check("underrun_so",        so0,              8'h00);
    check("underrun_out",       bus.Out,          8'hFF);
    check("underrun_nd_count",  8'(nd_count),     8'd4);

    // Abort after 5 bits, then a normal frame with a buffered byte
    cs_low(e0, ir2);
    xfer(8'hB7, 5, mi);
    cs_high();
    $display("abort    SI=B7 after 5 bits");
    check("abort_out",          bus.Out,          8'hFF);
    check("abort_nd_count",     8'(nd_count),     8'd4);
    load_byte(8'h5A);
    frame(1, 8'hC3, 8'h00, so0, so1, ir2);
    check("after_abort_so",     so0,              8'h5A);
    check("after_abort_out",    bus.Out,          8'hC3);
    check("after_abort_nd",     8'(nd_count),     8'd5);

    // Asynchronous reset during bit 4 with a byte buffered
    cs_low(e0, ir2);
    load_byte(8'h99);
    xfer(8'h6B, 3, mi);
    bus.SI = 1'b1;
    repeat (8) @(negedge Clock);
    bus.SClk = 1'b1;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    #1 check_reset("reset_mid");
    m_full = 1'b0;
    @(negedge Clock);
    bus.SClk = 1'b0;
    bus.CS_  = 1'b1;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    repeat (8) @(negedge Clock);
    $display("reset    asserted during bit 4");
    frame(1, 8'h66, 8'h00, so0, so1, ir2);
    check("post_reset_so",      so0,              8'h00);
    check("post_reset_out",     bus.Out,          8'h66);
    check("post_reset_nd",      8'(nd_count),     8'd6);
    check("rx_queue_drained",   8'(exp_rx.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
